// File: rtl/udm_bus_bridge.sv
// udm_bus_bridge: replays a udm debug-master request onto a req/ack system
// bus, with a watchdog that aborts unresponsive targets.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   s_enb_i/s_we_i/s_addr_bi/    udm request side (enb held until ack)
//   s_wdata_bi, s_ack_o,
//   s_rdata_bo
//   m_req_o/m_we_o/m_addr_bo/    system-bus side (req held until ack/abort)
//   m_wdata_bo, m_ack_i,
//   m_rdata_bi
//   timeout_o, timeout_cnt_bo    sticky abort flag, saturating abort count
module udm_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_enb_i,
    input  logic        s_we_i,
    input  logic [31:0] s_addr_bi,
    input  logic [31:0] s_wdata_bi,
    output logic        s_ack_o,
    output logic [31:0] s_rdata_bo,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_bo,
    output logic [31:0] m_wdata_bo,
    input  logic        m_ack_i,
    input  logic [31:0] m_rdata_bi,
    output logic        timeout_o,
    output logic [15:0] timeout_cnt_bo
);

    localparam int unsigned WD_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            req_q, req_d;
    logic            ack_q, ack_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            tmo_q, tmo_d;
    logic [15:0]     tcnt_q, tcnt_d;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        req_d   = req_q;
        ack_d   = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (s_enb_i) begin
                    we_d    = s_we_i;
                    addr_d  = s_addr_bi;
                    wdata_d = s_wdata_bi;
                    wd_d    = '0;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Saturation only matters with the watchdog disabled.
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
                // Ack takes priority over an abort in the same cycle.
                if (m_ack_i) begin
                    rdata_d = we_q ? 32'h0 : m_rdata_bi;
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
                    rdata_d = TIMEOUT_RDATA;
                    tmo_d   = 1'b1;
                    if (tcnt_q != 16'hFFFF) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Wait for udm to drop enb so one request yields one access.
                if (!s_enb_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            tmo_q   <= 1'b0;
            tcnt_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign s_ack_o        = ack_q;
    assign s_rdata_bo     = rdata_q;
    assign m_req_o        = req_q;
    assign m_we_o         = we_q;
    assign m_addr_bo      = addr_q;
    assign m_wdata_bo     = wdata_q;
    assign timeout_o      = tmo_q;
    assign timeout_cnt_bo = tcnt_q;

endmodule
